// File: rtl/axis_stream_pkg.sv
// Shared types and helpers for the AXI4-Stream concatenator and its output slice.
// Beat payload is width-generic, so it is provided as a macro taking the byte count.
`ifndef AXIS_STREAM_BEAT_T
`define AXIS_STREAM_BEAT_T(NB) struct packed { logic [(NB)*8-1:0] data; logic last; }
`endif

package axis_stream_pkg;

    // Select-register width; never zero even for a degenerate single-entry range.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// Two-entry skid buffer: registered data/valid/last toward the sink and a
// registered "not full" ready toward the source, sustaining one beat per cycle.
module axis_reg_slice #(
    parameter int unsigned N = 4
) (
    input  logic           clk_i,
    input  logic           reset_i,
    input  logic [N*8-1:0] s_data_i,
    input  logic           s_last_i,
    input  logic           s_valid_i,
    output logic           s_ready_o,
    output logic [N*8-1:0] m_data_o,
    output logic           m_last_o,
    output logic           m_valid_o,
    input  logic           m_ready_i
);

    typedef `AXIS_STREAM_BEAT_T(N) beat_t;

    beat_t main_q, main_d, skid_q, skid_d, in_beat;
    logic  main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
    logic  s_fire, m_fire;

    // Skid fills only when the output register is held by a stalled sink.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_vld_d   = main_vld_q;
        skid_vld_d   = skid_vld_q;
        in_beat.data = s_data_i;
        in_beat.last = s_last_i;
        s_fire       = s_valid_i & ~skid_vld_q;
        m_fire       = main_vld_q & m_ready_i;
        if (m_fire || !main_vld_q) begin
            if (skid_vld_q) begin
                main_d     = skid_q;
                main_vld_d = 1'b1;
                skid_vld_d = 1'b0;
            end else begin
                main_d     = in_beat;
                main_vld_d = s_fire;
            end
        end else if (s_fire) begin
            skid_d     = in_beat;
            skid_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
        end else begin
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
        end
    end

    always_ff @(posedge clk_i) begin
        main_q <= main_d;
        skid_q <= skid_d;
    end

    assign s_ready_o = ~skid_vld_q;
    assign m_data_o  = main_q.data;
    assign m_last_o  = main_q.last;
    assign m_valid_o = main_vld_q;

endmodule

// File: rtl/axis_stream_catenate.sv
// Concatenates one packet from each of S AXI4-Stream inputs, in index order, into one output packet.
// Define AXIS_STREAM_CATENATE_REG_OUT_EN to register the output through a skid slice (1-cycle latency).
module axis_stream_catenate
    import axis_stream_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned S = 2
) (
    input  logic             aclk,
    input  logic             reset,
    input  logic [S*N*8-1:0] axis_in_tdata,
    input  logic [S-1:0]     axis_in_tvalid,
    input  logic [S-1:0]     axis_in_tlast,
    output logic [S-1:0]     axis_in_tready,
    output logic [N*8-1:0]   axis_out_tdata,
    output logic             axis_out_tvalid,
    output logic             axis_out_tlast,
    input  logic             axis_out_tready
);

    localparam int unsigned   DW       = N * 8;
    localparam int unsigned   SW       = clog2_min1(S);
    localparam logic [SW-1:0] SEL_LAST = SW'(S - 1);

    logic [SW-1:0] sel_q, sel_d;
    logic [DW-1:0] mux_data;
    logic          mux_valid, mux_last, mux_last_in, mux_ready, accept;

    // Input mux; ready is a function of sel and downstream ready only, never of tvalid.
    always_comb begin
        mux_data       = '0;
        mux_valid      = 1'b0;
        mux_last_in    = 1'b0;
        axis_in_tready = '0;
        for (int unsigned i = 0; i < S; i++) begin
            if (sel_q == SW'(i)) begin
                mux_data          = axis_in_tdata[i*DW +: DW];
                mux_valid         = axis_in_tvalid[i] & ~reset;
                mux_last_in       = axis_in_tlast[i];
                axis_in_tready[i] = mux_ready & ~reset;
            end
        end
        // Only the final input's tlast terminates the merged packet.
        mux_last = mux_last_in & (sel_q == SEL_LAST);
    end

    always_comb begin
        sel_d  = sel_q;
        accept = mux_valid & mux_ready;
        if (accept && mux_last_in) begin
            sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            sel_q <= '0;
        end else begin
            sel_q <= sel_d;
        end
    end

`ifdef AXIS_STREAM_CATENATE_REG_OUT_EN
    logic slice_valid;

    axis_reg_slice #(.N(N)) u_out_slice (
        .clk_i     (aclk),
        .reset_i   (reset),
        .s_data_i  (mux_data),
        .s_last_i  (mux_last),
        .s_valid_i (mux_valid),
        .s_ready_o (mux_ready),
        .m_data_o  (axis_out_tdata),
        .m_last_o  (axis_out_tlast),
        .m_valid_o (slice_valid),
        .m_ready_i (axis_out_tready)
    );

    assign axis_out_tvalid = slice_valid & ~reset;
`else
    assign mux_ready       = axis_out_tready;
    assign axis_out_tdata  = mux_data;
    assign axis_out_tvalid = mux_valid;
    assign axis_out_tlast  = mux_last;
`endif

endmodule

// File: tb/tb_axis_stream_catenate.sv
// Randomized bench for axis_stream_catenate: packet-level scoreboard of {bias, vector} concatenations.
module tb_axis_stream_catenate;

    localparam int N  = 4;
    localparam int S  = 2;
    localparam int DW = N * 8;
`ifdef AXIS_STREAM_CATENATE_REG_OUT_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic            aclk = 1'b0;
    logic            reset;
    logic [S*DW-1:0] in_tdata;
    logic [S-1:0]    in_tvalid, in_tlast, in_tready;
    logic [DW-1:0]   out_tdata;
    logic            out_tvalid, out_tlast, out_tready;

    always #5 aclk = ~aclk;

    axis_stream_catenate #(.N(N), .S(S)) dut (
        .aclk            (aclk),
        .reset           (reset),
        .axis_in_tdata   (in_tdata),
        .axis_in_tvalid  (in_tvalid),
        .axis_in_tlast   (in_tlast),
        .axis_in_tready  (in_tready),
        .axis_out_tdata  (out_tdata),
        .axis_out_tvalid (out_tvalid),
        .axis_out_tlast  (out_tlast),
        .axis_out_tready (out_tready)
    );

    // Reference model: per-input packet queues, the expected merged stream,
    // and the input whose packet the merged stream is currently consuming.
    beat_t src_q[S][$];
    beat_t exp_q[$];
    bit    vld[S];
    int    cur;
    int    n_check, n_fail;
    int    n_out, n_last, n_in0, first_out, last_out;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_check++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic add_concat(input int len, input bit seq);
        beat_t b;
        b.data = 32'h3F80_0000;
        b.last = 1'b1;
        src_q[0].push_back(b);
        b.last = 1'b0;
        exp_q.push_back(b);
        for (int k = 0; k < len; k++) begin
            b.data = seq ? DW'(k + 1) : DW'($urandom);
            b.last = (k == len - 1);
            src_q[1].push_back(b);
            exp_q.push_back(b);
        end
    endtask

    task automatic flush_model();
        for (int i = 0; i < S; i++) begin
            src_q[i].delete();
            vld[i] = 1'b0;
        end
        exp_q.delete();
        cur = 0;
    endtask

    task automatic drive_inputs(input int vpct);
        for (int i = 0; i < S; i++) begin
            if (!vld[i] && src_q[i].size() > 0 && int'($urandom_range(99)) < vpct) vld[i] = 1'b1;
            in_tvalid[i] = vld[i];
            if (vld[i]) begin
                in_tdata[i*DW +: DW] = src_q[i][0].data;
                in_tlast[i]          = src_q[i][0].last;
            end else begin
                in_tdata[i*DW +: DW] = DW'($urandom);
                in_tlast[i]          = 1'($urandom);
            end
        end
    endtask

    // Per cycle: drive at negedge, observe handshakes 1 ns later, update model before posedge.
    task automatic run(input int vpct, input int rpct, input bit rpat, input int stop_out, input int max_cyc);
        logic [S-1:0] unsel;
        int           nxt;
        n_out     = 0;
        first_out = -1;
        last_out  = -1;
        for (int c = 0; c < max_cyc; c++) begin
            if (exp_q.size() == 0) break;
            if (stop_out > 0 && n_out >= stop_out) break;
            @(negedge aclk);
            drive_inputs(vpct);
            out_tready = rpat ? ((c % 4 == 0) || (c % 4 == 3)) : (int'($urandom_range(99)) < rpct);
            #1;
            unsel = in_tready & ~(S'(1) << cur);
            check_eq("unsel_ready", 64'(unsel), 64'(0));
`ifndef AXIS_STREAM_CATENATE_REG_OUT_EN
            check_eq("sel_ready", 64'(in_tready[cur]), 64'(out_tready));
            check_eq("out_valid", 64'(out_tvalid), 64'(in_tvalid[cur]));
`endif
            if (out_tvalid && out_tready) begin
                if (exp_q.size() == 0) begin
                    check_eq("extra_beat", 64'(1), 64'(0));
                end else begin
                    check_eq("beat", 64'({out_tdata, out_tlast}), 64'(exp_q[0]));
                    void'(exp_q.pop_front());
                end
                if (first_out < 0) first_out = c;
                last_out = c;
                n_out++;
                if (out_tlast) n_last++;
            end
            nxt = cur;
            for (int i = 0; i < S; i++) begin
                if (in_tvalid[i] && in_tready[i] && src_q[i].size() > 0) begin
                    if (i == 0) n_in0++;
                    if (src_q[i][0].last) nxt = (cur + 1) % S;
                    void'(src_q[i].pop_front());
                    vld[i] = 1'b0;
                end
            end
            cur = nxt;
        end
        if (stop_out == 0) begin
            check_eq("drain", 64'(exp_q.size()), 64'(0));
            check_eq("src_empty", 64'(src_q[0].size() + src_q[1].size()), 64'(0));
        end
    endtask

    // Idle with downstream ready: only input 0 may be offered ready (sel back at 0).
    task automatic check_idle_sel0(input string tag);
        @(negedge aclk);
        in_tvalid  = '0;
        out_tready = 1'b1;
        #1;
        check_eq(tag, 64'(in_tready), 64'(2'b01));
    endtask

    initial begin
        n_check = 0;
        n_fail  = 0;
        n_last  = 0;
        n_in0   = 0;
        flush_model();
        reset      = 1'b1;
        in_tvalid  = '1;
        in_tlast   = '1;
        in_tdata   = {32'hDEAD_BEEF, 32'h1234_5678};
        out_tready = 1'b1;

        // Reset: outputs forced low even with valid inputs and ready sink.
        repeat (3) @(negedge aclk);
        #1;
        check_eq("rst_ready", 64'(in_tready), 64'(0));
        check_eq("rst_valid", 64'(out_tvalid), 64'(0));
        @(negedge aclk);
        reset     = 1'b0;
        in_tvalid = '0;
        #1;
        check_eq("post_rst_ready", 64'(in_tready), 64'(2'b01));
        check_eq("post_rst_valid", 64'(out_tvalid), 64'(0));

        // Bias plus 3-beat vector, always valid and ready.
        add_concat(3, 1'b1);
        n_last = 0;
        run(100, 100, 1'b0, 0, 100);
        check_eq("s1_latency", 64'(first_out), 64'(LAT));
        check_eq("s1_span", 64'(last_out - first_out), 64'(3));
        check_eq("s1_tlast", 64'(n_last), 64'(1));
        check_idle_sel0("s1_sel0");

        // Backpressure with ready pattern 1,0,0,1.
        add_concat(3, 1'b1);
        run(100, 0, 1'b1, 0, 200);
        check_idle_sel0("s2_sel0");

        // Three back-to-back concatenations.
        n_last = 0;
        n_in0  = 0;
        for (int k = 0; k < 3; k++) add_concat(1 + k, 1'b0);
        run(100, 100, 1'b0, 0, 200);
        check_eq("s3_tlast", 64'(n_last), 64'(3));
        check_eq("s3_in0", 64'(n_in0), 64'(3));

        // Vector valid before bias: nothing from input 1 may leak.
        add_concat(2, 1'b0);
        vld[1] = 1'b1;
        @(negedge aclk);
        drive_inputs(0);
        out_tready = 1'b1;
        #1;
        check_eq("s4_ready", 64'(in_tready), 64'(2'b01));
        check_eq("s4_valid", 64'(out_tvalid), 64'(0));
        run(100, 100, 1'b0, 0, 200);

        // Reset after bias and one vector beat have left the output.
        add_concat(4, 1'b1);
        run(100, 100, 1'b0, 2, 100);
        @(negedge aclk);
        reset = 1'b1;
        #1;
        check_eq("s5_rst_ready", 64'(in_tready), 64'(0));
        check_eq("s5_rst_valid", 64'(out_tvalid), 64'(0));
        @(negedge aclk);
        reset = 1'b0;
        flush_model();
        check_idle_sel0("s5_sel0");
        add_concat(2, 1'b0);
        run(100, 100, 1'b0, 0, 100);

        // Randomized traffic with random valid gaps and backpressure.
        n_last = 0;
        n_in0  = 0;
        for (int k = 0; k < 40; k++) add_concat(int'($urandom_range(1, 6)), 1'b0);
        run(70, 60, 1'b0, 0, 5000);
        check_eq("rnd_tlast", 64'(n_last), 64'(40));
        check_eq("rnd_in0", 64'(n_in0), 64'(40));
        check_idle_sel0("rnd_sel0");

        $display("== %0d vectors applied, %0d miscompares ==", n_check, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_stream_catenate.md
Name: axis_stream_catenate

Overview:
- AXI4-Stream packet concatenator. Merges one packet from each of S input streams, taken in index order, into a single output packet.
- Used ahead of the dense-neuron MAC: input 0 carries a constant bias word (1.0, single beat, tlast=1) and input 1 carries the activation vector. The output packet is therefore {bias, x0..xn}.
- Pure flow-control and mux block. It performs no arithmetic on the data.

Parameters:
- N, 4, tdata width in bytes (data width = N*8 bits).
- S, 2, number of input streams (S >= 2).

Ports:
- aclk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- axis_in_tdata  in  S*N*8  input data; slice i occupies bits [(i+1)*N*8-1 : i*N*8].
- axis_in_tvalid  in  S  per-input valid.
- axis_in_tlast  in  S  per-input end-of-packet.
- axis_in_tready  out  S  per-input ready.
- axis_out_tdata  out  N*8  output data.
- axis_out_tvalid  out  1  output valid.
- axis_out_tlast  out  1  output end of the concatenated packet.
- axis_out_tready  in  1  downstream ready.

Behaviour:
- Select state sel, width $clog2(S), range 0..S-1. Reset value is 0.
- Default path is combinational, with zero latency:
  - axis_out_tvalid = axis_in_tvalid[sel]
  - axis_out_tdata = slice sel of axis_in_tdata
  - axis_out_tlast = axis_in_tlast[sel] AND (sel == S-1)
- axis_in_tready[i] = axis_out_tready when i == sel, otherwise 0. Non-selected inputs are always stalled.
- A beat is accepted when axis_in_tvalid[sel] and axis_out_tready are both 1.
- On an accepted beat with axis_in_tlast[sel]=1:
  - sel advances to sel+1.
  - If sel == S-1, sel wraps to 0.
- On an accepted beat with tlast=0, sel holds.
- A beat with tlast=1 on input i<S-1 is forwarded with axis_out_tlast=0. Internal packet boundaries are invisible downstream.
- Single-beat packets (e.g. bias) are legal and occupy exactly one output beat.
- Throughput is one beat per cycle. There is no bubble at a switch between inputs.
- Backpressure: when axis_out_tready=0, every axis_in_tready is 0 and sel holds.
- No combinational path from axis_in_tvalid to axis_in_tready. tready depends only on sel and axis_out_tready.
- Valid on an unselected input is ignored; that input's data is held upstream by AXIS rules.
- Reset mid-packet:
  - sel returns to 0 on the next edge.
  - While reset=1, all tready and axis_out_tvalid are forced to 0.
  - The partially sent packet is abandoned. Upstream sources are reset in the same domain.
- Outputs during and after reset: axis_out_tvalid=0 and axis_in_tready=0 while reset is asserted. After release, the outputs follow the combinational rules with sel=0.

Optional Feature:
- Macro: AXIS_STREAM_CATENATE_REG_OUT_EN.
- When defined, a two-entry skid register slice is inserted on the output:
  - tdata, tvalid and tlast become registered.
  - Latency is 1 cycle; full 1 beat/cycle throughput is kept.
  - axis_out_tready no longer reaches axis_in_tready combinationally. The internal mux ready is "slice not full".
  - On reset the slice is emptied and axis_out_tvalid=0.
- When undefined, the output is the zero-latency combinational path described above.

Decomposition:
- Package axis_stream_pkg:
  - localparam-free typedef helpers: a beat struct (data, last) parameterised by N via a macro or type parameter.
  - function clog2_min1 (returns at least 1, for the sel width).
- One sub-module, axis_reg_slice (skid buffer, params N), instantiated only under AXIS_STREAM_CATENATE_REG_OUT_EN.

Test Plan:
1. Bias plus vector:
   - Stimulus: in0 = 0x3F800000 (1.0) with tlast=1 held valid; in1 = 3 beats 0x1, 0x2, 0x3 with tlast on 0x3; out tready=1.
   - Required: output beats 0x3F800000, 0x1, 0x2, 0x3 on 4 consecutive cycles; tlast only on 0x3; then sel=0.
2. Backpressure:
   - Stimulus: same as scenario 1, with out tready toggled 1,0,0,1,...
   - Required: no beat lost or duplicated; in tready mirrors out tready for the selected input only; sel is stable during stalls.
3. Multi-packet wrap:
   - Stimulus: 3 back-to-back concatenations.
   - Required: output sequence repeats {bias, vector}; 3 tlast pulses; in0 accepted exactly 3 times.
4. Early valid on the unselected input:
   - Stimulus: in1 valid asserted while in0 is still invalid.
   - Required: axis_in_tready[1]=0, axis_out_tvalid=0, and no in1 data is output until the bias is accepted.
5. Reset mid-packet:
   - Stimulus: assert reset after the bias and 1 vector beat.
   - Required: next cycle has all tready=0 and out tvalid=0; after release, the next output beat comes from in0.
6. Macro on:
   - Stimulus: repeat scenarios 1 and 2 with AXIS_STREAM_CATENATE_REG_OUT_EN defined.
   - Required: identical beat sequence, first beat 1 cycle later, and 4 beats in 4 cycles at steady state.
